// File: rtl/ps_clk_meter_pkg.sv
// Shared types and defaults for the PS clock meter: FSM states, channel defaults,
// and the per-channel offset into the packed count bus.
package ps_inspect_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_e;

  localparam int DEF_NUM_CLKS    = 4;
  localparam int DEF_CNT_WIDTH   = 20;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_GATE_CYCLES = 100000;

  function automatic int cnt_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/ps_clk_meter_if.sv
// Meter bus: enable and divided clocks in, latched counts and flags out.
// No backpressure; results are published as a one-cycle count_valid pulse.
interface ps_clk_meter_if
  import ps_inspect_pkg::*;
#(
  parameter int NUM_CLKS  = DEF_NUM_CLKS,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);

  logic                          enable;
  logic [NUM_CLKS-1:0]           div_clk;
  logic [NUM_CLKS*CNT_WIDTH-1:0] freq_count;
  logic                          count_valid;
  logic [NUM_CLKS-1:0]           clk_alive;
  logic [NUM_CLKS-1:0]           cnt_overflow;
  logic                          window_busy;

  modport master (
    output enable, div_clk,
    input  freq_count, count_valid, clk_alive, cnt_overflow, window_busy
  );

  modport slave (
    input  enable, div_clk,
    output freq_count, count_valid, clk_alive, cnt_overflow, window_busy
  );

endinterface

// File: rtl/ps_clk_meter_edge_sync.sv
// Synchronizes one asynchronous divided clock and flags its rising edges.
// Latency SYNC_STAGES cycles to the rise pulse; no backpressure.
module clk_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_clk,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   hist;

  // History tracks the synchronized level every cycle so the measuring FSM
  // never sees a stale level when a window opens.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      hist <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], async_clk};
      hist <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/ps_clk_meter.sv
// Counts rising edges of each divided PS clock over a GATE_CYCLES window of ila_clk.
// Results land one cycle after the terminal window cycle with a count_valid pulse; no backpressure.
module ps_clk_meter
  import ps_inspect_pkg::*;
#(
  parameter int NUM_CLKS    = DEF_NUM_CLKS,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic           ila_clk,
  input  logic           rst,
  ps_clk_meter_if.slave  bus
);

  localparam int                   WIN_WIDTH = $clog2(GATE_CYCLES);
  localparam logic [WIN_WIDTH-1:0] WIN_LAST  = WIN_WIDTH'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  meter_state_e                       state;
  logic [WIN_WIDTH-1:0]               win_cnt;
  logic [NUM_CLKS-1:0]                rise;
  logic [NUM_CLKS-1:0][CNT_WIDTH-1:0] edge_cnt;
  logic [NUM_CLKS-1:0][CNT_WIDTH-1:0] cnt_nxt;
  logic [NUM_CLKS-1:0]                sticky;
  logic [NUM_CLKS-1:0]                sticky_nxt;

  for (genvar i = 0; i < NUM_CLKS; i++) begin : g_sync
    clk_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (ila_clk),
      .rst       (rst),
      .async_clk (bus.div_clk[i]),
      .rise      (rise[i])
    );
  end

  // Saturating next count; overflow is flagged once a channel reaches the cap.
  always_comb begin
    cnt_nxt    = edge_cnt;
    sticky_nxt = sticky;
    for (int i = 0; i < NUM_CLKS; i++) begin
      if (rise[i] && (edge_cnt[i] != CNT_MAX)) begin
        cnt_nxt[i] = edge_cnt[i] + CNT_WIDTH'(1);
      end
      sticky_nxt[i] = sticky[i] | (cnt_nxt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge ila_clk) begin
    if (rst) begin
      state            <= IDLE;
      win_cnt          <= '0;
      edge_cnt         <= '0;
      sticky           <= '0;
      bus.freq_count   <= '0;
      bus.count_valid  <= 1'b0;
      bus.clk_alive    <= '0;
      bus.cnt_overflow <= '0;
      bus.window_busy  <= 1'b0;
    end else begin
      bus.count_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            state           <= MEASURE;
            win_cnt         <= '0;
            edge_cnt        <= '0;
            sticky          <= '0;
            bus.window_busy <= 1'b1;
          end
        end
        MEASURE: begin
          if (win_cnt == WIN_LAST) begin
            // Terminal cycle: an edge arriving now still belongs to this window.
            for (int i = 0; i < NUM_CLKS; i++) begin
              bus.freq_count[cnt_lsb(i, CNT_WIDTH) +: CNT_WIDTH] <= cnt_nxt[i];
              bus.clk_alive[i] <= (cnt_nxt[i] != '0);
            end
            bus.cnt_overflow <= sticky_nxt;
            bus.count_valid  <= 1'b1;
            win_cnt          <= '0;
            edge_cnt         <= '0;
            sticky           <= '0;
            if (!bus.enable) begin
              state           <= IDLE;
              bus.window_busy <= 1'b0;
            end
          end else if (!bus.enable) begin
            state           <= IDLE;
            bus.window_busy <= 1'b0;
          end else begin
            win_cnt  <= win_cnt + WIN_WIDTH'(1);
            edge_cnt <= cnt_nxt;
            sticky   <= sticky_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ps_clk_meter.md
Name: ps_clk_meter

Overview:
Frequency meter that consumes the divided PS fabric clocks (div_pl_clk_0..3) produced by the prescaler stage. It samples each divided clock as asynchronous data in the ila_clk domain and counts rising edges over a fixed gate window. It publishes per-channel counts, alive and overflow flags for ILA probing, which lets software or the ILA confirm PS clock frequencies without a scope.

Parameters:
NUM_CLKS, 4, number of divided-clock channels measured
GATE_CYCLES, 100000, gate window length in ila_clk cycles (>= 2)
CNT_WIDTH, 20, width of each per-channel edge count
SYNC_STAGES, 2, synchronizer flops per channel (>= 2)

Ports:
ila_clk  input  1  measurement clock; all logic in this domain
rst  input  1  synchronous, active-high reset
enable  input  1  high = run continuous gate windows; low = idle
div_clk  input  NUM_CLKS  divided PS clocks, asynchronous to ila_clk, bit i = div_pl_clk_i
freq_count  output  NUM_CLKS*CNT_WIDTH  latched edge counts; channel i at bits [i*CNT_WIDTH +: CNT_WIDTH]
count_valid  output  1  one-cycle pulse when freq_count/flags update
clk_alive  output  NUM_CLKS  bit i = 1 if channel i latched count nonzero
cnt_overflow  output  NUM_CLKS  bit i = 1 if channel i saturated in last window
window_busy  output  1  high while a gate window is in progress

Behaviour:
- Reset: all outputs 0; state IDLE; window counter, edge counters, synchronizer and history flops cleared.
- Per channel: SYNC_STAGES-flop synchronizer, then history flop. Rising edge = sync_out & ~history. History flop updates every cycle, including IDLE, so entering MEASURE never produces a spurious edge.
- Input constraint: div_clk high and low phases each >= 2 ila_clk periods. Accuracy under this constraint is +/-1 count per window.
- FSM states are IDLE and MEASURE.
  - IDLE -> MEASURE on the cycle after enable is sampled high. The window counter loads 0, the edge counters load 0, and window_busy goes high.
  - MEASURE: the window counter increments 0..GATE_CYCLES-1. On each detected edge, the edge counter increments.
  - Edge counter saturates at 2^CNT_WIDTH-1. On saturation the channel's overflow sticky bit is set for the current window.
  - Terminal cycle (window count == GATE_CYCLES-1): next-state counts (including any edge on this cycle) and sticky bits are registered into freq_count/cnt_overflow. clk_alive is set per channel to (count != 0).
  - count_valid pulses high on the cycle after the terminal cycle, coincident with the new output values.
  - After the terminal cycle, edge counters and sticky bits clear, and the next window starts immediately with no dead cycle if enable is still high. Otherwise the FSM returns to IDLE and window_busy drops.
- enable low mid-window: abort to IDLE on the next cycle. Partial counts are discarded, no count_valid pulse is issued, and freq_count/clk_alive/cnt_overflow retain the previous window's values.
- rst mid-window: immediate return to reset values on the next edge. Outputs are cleared and there is no count_valid.
- Edge and terminal cycle coincide: the edge is counted in the closing window, and the new window starts at 0.
- Window counter width is $clog2(GATE_CYCLES).

Decomposition:
- Package ps_inspect_pkg holds:
  - FSM state enum {IDLE, MEASURE}
  - default constants for NUM_CLKS, CNT_WIDTH, SYNC_STAGES
  - helper function for the count slice offset
- One sub-module, clk_edge_sync: SYNC_STAGES synchronizer plus history flop plus rising-edge pulse output. It is instantiated NUM_CLKS times via generate.
- The FSM, window counter and per-channel counters live in ps_clk_meter.

Test Plan:
- ila_clk 100 MHz, GATE_CYCLES=1000, div_clk[0] period 8 ila_clk -> freq_count ch0 = 125 +/-1, clk_alive[0]=1, cnt_overflow[0]=0, count_valid every 1000 cycles.
- div_clk[1] held 0 for full window -> ch1 count 0, clk_alive[1]=0. Then restart toggling at period 10 -> next window count 100 +/-1, alive=1.
- CNT_WIDTH=6, GATE_CYCLES=1000, period 4 -> count saturates at 63, cnt_overflow=1. Then period 40 in the next window -> 25 +/-1, overflow=0.
- After a completed window (ch0=125), drop enable at window cycle 500 -> no count_valid, ch0 stays 125, window_busy=0 next cycle. Re-enable -> the next valid arrives 1001 cycles after enable is sampled.
- Assert rst for 1 cycle mid-window -> all outputs 0, FSM IDLE. Rerun -> correct counts.
- Force a div_clk rising edge exactly at window count 999 -> the edge is included in the closing count (e.g. 125 not 124), and the next window starts from 0.
